// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default tap count, sample-width helper and the
// averager state encoding.
package tdc_pkg;

  localparam int TDC_N = 64;

  // A pop count over n taps spans 0..n inclusive, hence the extra bit.
  function automatic int sample_w(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {
    AVG_IDLE,
    AVG_ACCUM,
    AVG_DONE
  } avg_state_t;

endpackage

// File: rtl/tdc_sample_averager_if.sv
// Control, sample and result bundle between the averager and its
// producer/readout logic.
interface tdc_sample_averager_if
  import tdc_pkg::*;
#(
  parameter int N            = TDC_N,
  parameter int LOG2_WIN_MAX = 8
) ();

  localparam int W  = sample_w(N);
  localparam int SW = W + LOG2_WIN_MAX;
  localparam int KW = $clog2(LOG2_WIN_MAX + 1);

  logic          start;
  logic [KW-1:0] log2_win;
  logic          sample_valid;
  logic [W-1:0]  sample;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [W-1:0]  out_mean;
  logic [W-1:0]  out_min;
  logic [W-1:0]  out_max;
  logic          overrun;

  modport slave (
    input  start, log2_win, sample_valid, sample, out_ready,
    output busy, out_valid, out_sum, out_mean, out_min, out_max, overrun
  );

  modport master (
    output start, log2_win, sample_valid, sample, out_ready,
    input  busy, out_valid, out_sum, out_mean, out_min, out_max, overrun
  );

endinterface

// File: rtl/tdc_minmax_tracker.sv
// Running min/max of the samples in the current window. Outputs are the
// look-ahead values that already include a sample accepted this cycle.
module tdc_minmax_tracker #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_first_i,
  input  logic         valid_i,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] min_o,
  output logic [W-1:0] max_o
);

  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    min_d = min_q;
    max_d = max_q;
    if (clr_i) begin
      min_d = '0;
      max_d = '0;
    end else if (valid_i) begin
      if (load_first_i) begin
        min_d = sample_i;
        max_d = sample_i;
      end else begin
        if (sample_i < min_q) min_d = sample_i;
        if (sample_i > max_q) max_d = sample_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_d;
  assign max_o = max_d;

endmodule

// File: rtl/tdc_sample_averager.sv
// Accumulates a window of 2^k TDC pop counts and presents sum, truncated
// mean, min and max through a valid/ready result register.
module tdc_sample_averager
  import tdc_pkg::*;
#(
  parameter int N            = TDC_N,
  parameter int LOG2_WIN_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tdc_sample_averager_if.slave  bus
);

  localparam int W  = sample_w(N);
  localparam int SW = W + LOG2_WIN_MAX;
  localparam int KW = $clog2(LOG2_WIN_MAX + 1);
  localparam int CW = LOG2_WIN_MAX + 1;

  avg_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  mean_q, mean_d;
  logic [W-1:0]  min_q, min_d;
  logic [W-1:0]  max_q, max_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;

  logic [KW-1:0] k_clamped;
  logic [CW-1:0] cnt_last;
  logic [SW-1:0] sample_ext;
  logic [SW-1:0] sum_final;
  logic          trk_clr;
  logic          trk_valid;
  logic [W-1:0]  trk_min;
  logic [W-1:0]  trk_max;

  assign k_clamped  = (bus.log2_win > KW'(LOG2_WIN_MAX)) ? KW'(LOG2_WIN_MAX) : bus.log2_win;
  assign cnt_last   = (CW'(1) << k_q) - CW'(1);
  assign sample_ext = SW'(bus.sample);
  assign sum_final  = acc_q + sample_ext;
  assign trk_clr    = (state_q == AVG_IDLE) && bus.start;
  assign trk_valid  = (state_q == AVG_ACCUM) && bus.sample_valid;

  tdc_minmax_tracker #(.W(W)) u_minmax (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (trk_clr),
    .load_first_i (cnt_q == '0),
    .valid_i      (trk_valid),
    .sample_i     (bus.sample),
    .min_o        (trk_min),
    .max_o        (trk_max)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    min_d       = min_q;
    max_d       = max_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      AVG_IDLE: begin
        if (bus.start) begin
          k_d       = k_clamped;
          acc_d     = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = AVG_ACCUM;
        end
      end

      AVG_ACCUM: begin
        if (bus.sample_valid) begin
          acc_d = sum_final;
          cnt_d = cnt_q + CW'(1);
          // The 2^k-th sample closes the window; results include it directly.
          if (cnt_q == cnt_last) begin
            sum_d       = sum_final;
            mean_d      = W'(sum_final >> k_q);
            min_d       = trk_min;
            max_d       = trk_max;
            out_valid_d = 1'b1;
            state_d     = AVG_DONE;
          end
        end
      end

      AVG_DONE: begin
        if (bus.sample_valid) overrun_d = 1'b1;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = AVG_IDLE;
        end
      end

      default: state_d = AVG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= AVG_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      mean_q      <= '0;
      min_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
      min_q       <= min_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.busy      = (state_q == AVG_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_mean  = mean_q;
  assign bus.out_min   = min_q;
  assign bus.out_max   = max_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_tdc_sample_averager.sv
// Scenario bench for tdc_sample_averager: directed cases plus random windows
// checked against a plain-arithmetic window model.
module tb_tdc_sample_averager;
  import tdc_pkg::*;

  localparam int N   = TDC_N;
  localparam int LWM = 8;
  localparam int W   = sample_w(N);
  localparam int SW  = W + LWM;
  localparam int KW  = $clog2(LWM + 1);
  localparam int RW  = SW + 3 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tdc_sample_averager_if #(.N(N), .LOG2_WIN_MAX(LWM)) dut_if ();

  tdc_sample_averager #(.N(N), .LOG2_WIN_MAX(LWM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {sum, mean, min, max} of a window, straight from the definition.
  function automatic logic [RW-1:0] model(input int k_req, input int q[$]);
    int k, sum, mn, mx;
    k   = (k_req > LWM) ? LWM : k_req;
    sum = 0;
    mn  = q[0];
    mx  = q[0];
    foreach (q[i]) begin
      sum += q[i];
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
    return {SW'(sum), W'(sum / (1 << k)), W'(mn), W'(mx)};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {dut_if.out_sum, dut_if.out_mean, dut_if.out_min, dut_if.out_max};
  endfunction

  // Start a window and feed q; flags busy/out_valid/overrun misbehaviour before the last sample.
  task automatic drive_window(input int k_req, input int q[$], input int gap, output bit bad);
    bad = 1'b0;
    dut_if.start    = 1'b1;
    dut_if.log2_win = KW'(k_req);
    step();
    dut_if.start = 1'b0;
    if (!dut_if.busy || dut_if.out_valid || dut_if.overrun) bad = 1'b1;
    foreach (q[i]) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      dut_if.sample = W'($urandom_range(0, N));
      repeat (g) begin
        step();
        if (dut_if.out_valid || !dut_if.busy) bad = 1'b1;
      end
      dut_if.sample_valid = 1'b1;
      dut_if.sample       = W'(q[i]);
      step();
      dut_if.sample_valid = 1'b0;
      if (i != q.size() - 1 && (dut_if.out_valid || !dut_if.busy)) bad = 1'b1;
    end
  endtask

  task automatic handshake();
    dut_if.out_ready = 1'b1;
    step();
    dut_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({dut_if.busy, dut_if.out_valid, dut_if.overrun, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h, expected all zero",
               {dut_if.busy, dut_if.out_valid, dut_if.overrun, observed()});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({dut_if.busy, dut_if.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/out_valid=%b, expected 00", {dut_if.busy, dut_if.out_valid});
    end
  endtask

  task automatic test_k2();
    int q[$] = '{10, 20, 30, 41};
    bit bad;
    drive_window(2, q, 0, bad);
    checks++;
    if (bad) begin errors++; $display("FAIL k2_protocol: early completion or bad busy, expected none"); end
    checks++;
    if ({dut_if.out_valid, dut_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL k2_done_flags: out_valid/busy=%b, expected 10", {dut_if.out_valid, dut_if.busy});
    end
    checks++;
    if (observed() !== {15'd101, 7'd25, 7'd10, 7'd41}) begin
      errors++;
      $display("FAIL k2_result: got sum=%0d mean=%0d min=%0d max=%0d, expected 101 25 10 41",
               dut_if.out_sum, dut_if.out_mean, dut_if.out_min, dut_if.out_max);
    end
    step();
    checks++;
    if ({dut_if.out_valid, dut_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL k2_hold: out_valid/busy=%b, expected 10", {dut_if.out_valid, dut_if.busy});
    end
    handshake();
    checks++;
    if (dut_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL k2_handshake: out_valid=%b, expected 0", dut_if.out_valid);
    end
  endtask

  task automatic test_gapped();
    int q[$] = '{64, 64, 64, 64, 64, 64, 64, 64};
    bit bad;
    drive_window(3, q, 1, bad);
    checks++;
    if (bad || dut_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gapped_timing: bad=%b out_valid=%b, expected 0 and 1", bad, dut_if.out_valid);
    end
    checks++;
    if (observed() !== {15'd512, 7'd64, 7'd64, 7'd64}) begin
      errors++;
      $display("FAIL gapped_result: got %h, expected %h", observed(), {15'd512, 7'd64, 7'd64, 7'd64});
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int q[$];
    bit bad;
    logic [RW-1:0] exp;
    for (int i = 0; i < 4; i++) q.push_back(int'($urandom_range(0, N)));
    exp = model(2, q);
    drive_window(2, q, 0, bad);
    for (int c = 0; c < 5; c++) begin
      dut_if.sample_valid = (c == 1 || c == 3);
      dut_if.sample       = W'($urandom_range(0, N));
      step();
    end
    dut_if.sample_valid = 1'b0;
    checks++;
    if (observed() !== exp || dut_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable: got %h valid=%b, expected %h valid=1", observed(), dut_if.out_valid, exp);
    end
    checks++;
    if (dut_if.overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b, expected 1", dut_if.overrun); end
    handshake();
    checks++;
    if ({dut_if.out_valid, dut_if.overrun} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: out_valid/overrun=%b, expected 01", {dut_if.out_valid, dut_if.overrun});
    end
    dut_if.start    = 1'b1;
    dut_if.log2_win = KW'(0);
    step();
    dut_if.start = 1'b0;
    checks++;
    if ({dut_if.busy, dut_if.overrun} !== 2'b10) begin
      errors++;
      $display("FAIL bp_overrun_clear: busy/overrun=%b, expected 10", {dut_if.busy, dut_if.overrun});
    end
    dut_if.sample_valid = 1'b1;
    step();
    dut_if.sample_valid = 1'b0;
    handshake();
  endtask

  task automatic test_clamp_and_zero();
    int q[$];
    bit bad;
    for (int i = 0; i < 256; i++) q.push_back(64);
    drive_window(15, q, 0, bad);
    checks++;
    if (bad || dut_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clamp_timing: bad=%b out_valid=%b, expected 0 and 1", bad, dut_if.out_valid);
    end
    checks++;
    if (observed() !== {15'd16384, 7'd64, 7'd64, 7'd64}) begin
      errors++;
      $display("FAIL clamp_result: got sum=%0d mean=%0d, expected 16384 64", dut_if.out_sum, dut_if.out_mean);
    end
    handshake();
    q = '{0};
    drive_window(0, q, 0, bad);
    checks++;
    if (bad || dut_if.out_valid !== 1'b1 || observed() !== '0) begin
      errors++;
      $display("FAIL k0_zero: bad=%b valid=%b result=%h, expected 0 1 0", bad, dut_if.out_valid, observed());
    end
    handshake();
  endtask

  task automatic test_ignored_inputs();
    int vals[4] = '{10, 11, 12, 13};
    dut_if.start    = 1'b1;
    dut_if.log2_win = KW'(2);
    step();
    for (int i = 0; i < 4; i++) begin
      dut_if.start        = (i == 2);
      dut_if.log2_win     = KW'(0);
      dut_if.sample_valid = 1'b1;
      dut_if.sample       = W'(vals[i]);
      step();
      dut_if.start        = 1'b0;
      dut_if.sample_valid = 1'b0;
      if (i == 2) begin
        checks++;
        if (dut_if.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL accum_start_ignored: out_valid=%b after 3rd sample, expected 0", dut_if.out_valid);
        end
      end
    end
    checks++;
    if (dut_if.out_valid !== 1'b1 || observed() !== {15'd46, 7'd11, 7'd10, 7'd13}) begin
      errors++;
      $display("FAIL accum_start_result: valid=%b got %h, expected 1 %h",
               dut_if.out_valid, observed(), {15'd46, 7'd11, 7'd10, 7'd13});
    end
    // Start coincident with the handshake must be dropped.
    dut_if.out_ready = 1'b1;
    dut_if.start     = 1'b1;
    step();
    dut_if.out_ready = 1'b0;
    checks++;
    if ({dut_if.busy, dut_if.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL hs_start_ignored: busy/out_valid=%b, expected 00", {dut_if.busy, dut_if.out_valid});
    end
    // Earliest legal start, with a coincident sample that must not count.
    dut_if.start        = 1'b1;
    dut_if.log2_win     = KW'(0);
    dut_if.sample_valid = 1'b1;
    dut_if.sample       = W'(5);
    step();
    dut_if.start = 1'b0;
    dut_if.sample = W'(7);
    checks++;
    if ({dut_if.busy, dut_if.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL coincident_start: busy/out_valid=%b, expected 10", {dut_if.busy, dut_if.out_valid});
    end
    step();
    dut_if.sample_valid = 1'b0;
    checks++;
    if (dut_if.out_valid !== 1'b1 || observed() !== {15'd7, 7'd7, 7'd7, 7'd7}) begin
      errors++;
      $display("FAIL coincident_result: valid=%b sum=%0d, expected 1 7", dut_if.out_valid, dut_if.out_sum);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int q[$] = '{3, 4, 5};
    bit bad;
    drive_window(2, q, 0, bad);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({dut_if.busy, dut_if.out_valid, dut_if.overrun, observed()} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got %h, expected all zero",
               {dut_if.busy, dut_if.out_valid, dut_if.overrun, observed()});
    end
    dut_if.sample_valid = 1'b1;
    dut_if.sample       = W'(9);
    step();
    dut_if.sample_valid = 1'b0;
    checks++;
    if ({dut_if.busy, dut_if.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_idle: busy/out_valid=%b, expected 00", {dut_if.busy, dut_if.out_valid});
    end
    q = '{1, 2, 3, 4};
    drive_window(2, q, 0, bad);
    checks++;
    if (bad || dut_if.out_valid !== 1'b1 || observed() !== {15'd10, 7'd2, 7'd1, 7'd4}) begin
      errors++;
      $display("FAIL midreset_fresh: bad=%b valid=%b got %h, expected 0 1 %h",
               bad, dut_if.out_valid, observed(), {15'd10, 7'd2, 7'd1, 7'd4});
    end
    handshake();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int k_req, k, wait_c;
      int q[$];
      bit bad, exp_ovr;
      logic [RW-1:0] exp;
      k_req = (it == 5) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 4));
      k     = (k_req > LWM) ? LWM : k_req;
      for (int j = 0; j < (1 << k); j++) q.push_back(int'($urandom_range(0, N)));
      exp = model(k_req, q);
      drive_window(k_req, q, -1, bad);
      checks++;
      if (bad || dut_if.out_valid !== 1'b1 || observed() !== exp) begin
        errors++;
        $display("FAIL rand_window[%0d] k=%0d: bad=%b valid=%b got %h, expected %h",
                 it, k_req, bad, dut_if.out_valid, observed(), exp);
      end
      exp_ovr = 1'b0;
      wait_c  = int'($urandom_range(0, 3));
      repeat (wait_c) begin
        dut_if.sample_valid = 1'($urandom_range(0, 1));
        exp_ovr |= dut_if.sample_valid;
        step();
      end
      dut_if.sample_valid = 1'($urandom_range(0, 1));
      exp_ovr |= dut_if.sample_valid;
      handshake();
      dut_if.sample_valid = 1'b0;
      checks++;
      if ({dut_if.out_valid, dut_if.busy, dut_if.overrun} !== {2'b00, exp_ovr}) begin
        errors++;
        $display("FAIL rand_release[%0d]: valid/busy/overrun=%b, expected %b",
                 it, {dut_if.out_valid, dut_if.busy, dut_if.overrun}, {2'b00, exp_ovr});
      end
    end
  endtask

  initial begin
    dut_if.start        = 1'b0;
    dut_if.log2_win     = '0;
    dut_if.sample_valid = 1'b0;
    dut_if.sample       = '0;
    dut_if.out_ready    = 1'b0;
    test_reset();
    test_k2();
    test_gapped();
    test_backpressure();
    test_clamp_and_zero();
    test_ignored_inputs();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_sample_averager.md
# tdc_sample_averager

Post-processing stage that sits directly downstream of the TDC pop-count register. It consumes one registered thermometer pop count per qualified cycle and accumulates a window of 2^k samples. It then presents sum, truncated mean, minimum and maximum through a valid/ready output register for readout logic. Accumulation is started explicitly, so software-driven measurement bursts line up with the delay-line capture.

## Interface
- N, 64, delay-line tap count; input sample width W = $clog2(N)+1 (values 0..N)
- LOG2_WIN_MAX, 8, largest supported window exponent; accumulator width SW = W+LOG2_WIN_MAX
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a window; honoured only in IDLE
- log2_win  input  $clog2(LOG2_WIN_MAX+1)  window exponent k, sampled on accepted start
- sample_valid  input  1  sample qualifier, driven by the pop-count register's enable delayed one cycle
- sample  input  W  pop count
- busy  output  1  high in ACCUM
- out_valid  output  1  result register holds an unconsumed window
- out_ready  input  1  consumer accepts result
- out_sum  output  SW  sum of window samples
- out_mean  output  W  out_sum >> k (truncating)
- out_min  output  W  smallest sample in window
- out_max  output  W  largest sample in window
- overrun  output  1  sticky: a valid sample arrived while in DONE

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: start=1 latches k = min(log2_win, LOG2_WIN_MAX), clears the accumulator and sample counter, clears overrun, and moves to ACCUM. Samples in IDLE are dropped silently.
- ACCUM: each sample_valid adds sample to acc (SW bits, zero-extended) and increments cnt.
  - The first sample of the window loads min and max directly.
  - Later samples update min and max by unsigned compare.
  - start is ignored.
  - When the accepted sample is number 2^k (cnt reaches 2^k-1 before increment), the output registers load acc+sample, mean, and the final min/max, out_valid is set, and the state moves to DONE.
- DONE: outputs are held stable. On out_valid && out_ready, out_valid clears and the state moves to IDLE. A sample_valid in DONE sets overrun and is discarded. start is ignored.
- k=0: the window is one sample; sum = mean = min = max = that sample.
- Arithmetic: no saturation is needed, because 2^LOG2_WIN_MAX·N fits SW bits. Mean is truncation of the sum, with no rounding.
- Reset mid-window: the window is abandoned and all state returns to reset values. No partial result is emitted.

## Timing
- Reset values: busy 0, out_valid 0, out_sum 0, out_mean 0, out_min 0, out_max 0, overrun 0, state IDLE.
- Start accepted at edge t: busy=1 from t+1. Samples are counted on edges t+1 onward. A sample_valid in the same cycle as start is not counted.
- Last sample at edge t_L: out_valid=1 and all results are valid after t_L, and busy=0 after t_L.
- Handshake at edge t_H: out_valid=0 after t_H, and the state is IDLE. A start in the t_H cycle is ignored; the earliest new start is accepted at t_H+1.
- Minimum window period: 2^k+2 cycles (start, 2^k samples, handshake with out_ready held high).
- Output registers change only on window completion or reset.
- overrun stays high until the next accepted start or reset.

## Structure
- Shared tdc_pkg holds:
  - TDC_N
  - function sample_w(N) = $clog2(N)+1
  - typedef enum logic [1:0] avg_state_t {AVG_IDLE, AVG_ACCUM, AVG_DONE}
- Sub-module tdc_minmax_tracker (inputs clr, load_first, valid, sample; outputs min, max) keeps the compare logic out of the FSM. Everything else lives in one module.

## Test plan
- Reset and k=2: after rst, start with log2_win=2, then samples 10,20,30,41 on consecutive valid cycles.
  - Required response: out_sum=101, out_mean=25, out_min=10, out_max=41, out_valid one cycle after 41, busy low from then on.
- Gapped valids with k=3: eight samples of 64 with sample_valid low on alternate cycles.
  - Required response: sum=512, mean=64, min=max=64; out_valid only after the eighth valid.
- Back-pressure: hold out_ready=0 for 5 cycles after completion and inject 2 valid samples meanwhile.
  - Required response: results stable and overrun=1. After out_ready=1, out_valid drops next cycle. The next start clears overrun.
- Clamp and boundary with N=64, LOG2_WIN_MAX=8:
  - log2_win=15 behaves as k=8.
  - 256 samples of 64 give out_sum=16384 and mean=64, with no overflow.
  - A k=0 window with sample 0 gives all outputs 0.
- Ignored inputs:
  - start during ACCUM does not restart the count.
  - start in the handshake cycle is ignored.
  - sample_valid coincident with the accepted start is not counted (start+5 with k=0, then sample 7, gives sum 7).
- Reset mid-window: after 3 of 4 samples, assert rst for one cycle.
  - Required response: all outputs 0, no out_valid.
  - A fresh window then completes normally.
